// File: rtl/kw_arb_rr_onehot_if.sv
// Handshake bundle between requesters, the one-hot mux select and the downstream consumer.
// Pure wiring: no latency of its own.
// Backpressure is carried by ready; the arbiter side drives grant/valid/ack.
interface kw_arb_rr_onehot_if #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]    req;
    logic            ready;
    logic [N-1:0]    grant_onehot;
    logic [IDXW-1:0] grant_idx;
    logic            valid;
    logic [N-1:0]    ack;

    modport master (
        input  req,
        input  ready,
        output grant_onehot,
        output grant_idx,
        output valid,
        output ack
    );

    modport slave (
        output req,
        output ready,
        input  grant_onehot,
        input  grant_idx,
        input  valid,
        input  ack
    );
endinterface

// File: rtl/kw_arb_rr_onehot.sv
// Round-robin arbiter producing a one-hot mux select plus one valid/ready handshake downstream.
// Latency: grant is combinational from req in IDLE (0 cycles); back-to-back transfers every cycle.
// Backpressure: while ready is low the grant is frozen in HOLD so the muxed data cannot change.
module kw_arb_rr_onehot #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
) (
    input logic                i_clk,
    input logic                i_rst_n,
    kw_arb_rr_onehot_if.master arb
);
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [N-1:0]    held_q, held_d;

    logic [N-1:0]    rr_grant;
    logic [N-1:0]    grant;
    logic [IDXW-1:0] grant_idx;
    logic            valid;
    logic            xfer;

    // Rotating search starting at ptr; the first set request wins.
    always_comb begin
        int              k;
        logic            found;
        logic [IDXW-1:0] kk;
        rr_grant = '0;
        found    = 1'b0;
        k        = 0;
        kk       = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) begin
                k = k - N;
            end
            kk = IDXW'(k);
            if (!found && arb.req[kk]) begin
                found        = 1'b1;
                rr_grant[kk] = 1'b1;
            end
        end
    end

    // Outputs are forced to zero while reset is asserted.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (i_rst_n) begin
            grant = (state_q == HOLD) ? held_q : rr_grant;
        end
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx = grant_idx | IDXW'(i);
            end
        end
    end

    assign valid = |grant;
    assign xfer  = valid & arb.ready;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        held_d  = held_q;
        if (xfer) begin
            // Explicit wrap so a non-power-of-two N never lets ptr reach N.
            ptr_d   = (grant_idx == IDXW'(N - 1)) ? '0 : grant_idx + IDXW'(1);
            state_d = IDLE;
        end else if (valid && (state_q == IDLE)) begin
            held_d  = grant;
            state_d = HOLD;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            held_q  <= held_d;
        end
    end

    assign arb.grant_onehot = grant;
    assign arb.grant_idx    = grant_idx;
    assign arb.valid        = valid;
    assign arb.ack          = grant & {N{arb.ready}};
endmodule

// File: tb/tb_kw_arb_rr_onehot.sv
// Bench for kw_arb_rr_onehot: directed vector tables for N=4 and N=3, then random traffic
// checked against a queue-free behavioural round-robin model.
module tb_kw_arb_rr_onehot;
    logic clk;
    logic rst4_n;
    logic rst3_n;
    int   checks;
    int   errors;

    kw_arb_rr_onehot_if #(.N(4)) if4 ();
    kw_arb_rr_onehot_if #(.N(3)) if3 ();

    kw_arb_rr_onehot #(.N(4)) dut4 (.i_clk(clk), .i_rst_n(rst4_n), .arb(if4.master));
    kw_arb_rr_onehot #(.N(3)) dut3 (.i_clk(clk), .i_rst_n(rst3_n), .arb(if3.master));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] eg;
        logic [1:0] ei;
        logic [3:0] ea;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic y,
                                input logic [3:0] g, input logic [1:0] i, input logic [3:0] a);
        vec_t v;
        v.rst_n = r; v.req = q; v.rdy = y; v.eg = g; v.ei = i; v.ea = a;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive at posedge+1, compare mid-cycle, advance to next posedge+1.
    task automatic cyc(input int n, input vec_t v, input string nm);
        logic [3:0] g, a;
        logic [1:0] ix;
        logic       vl;
        if (n == 3) begin
            rst3_n = v.rst_n; if3.req = v.req[2:0]; if3.ready = v.rdy;
        end else begin
            rst4_n = v.rst_n; if4.req = v.req; if4.ready = v.rdy;
        end
        #4;
        if (n == 3) begin
            g = {1'b0, if3.grant_onehot}; ix = if3.grant_idx; vl = if3.valid; a = {1'b0, if3.ack};
        end else begin
            g = if4.grant_onehot; ix = if4.grant_idx; vl = if4.valid; a = if4.ack;
        end
        chk({nm, " grant"}, 32'(g), 32'(v.eg));
        chk({nm, " idx"},   32'(ix), 32'(v.ei));
        chk({nm, " valid"}, 32'(vl), 32'(|v.eg));
        chk({nm, " ack"},   32'(a), 32'(v.ea));
        @(posedge clk);
        #1;
    endtask

    // Reference: held grant wins; otherwise first request scanning ptr, ptr+1, ... modulo n.
    function automatic int mgrant(input int n, input int ptr, input int held, input logic [3:0] req);
        if (held >= 0) return held;
        for (int i = 0; i < n; i++) begin
            if (req[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    task automatic rand_run(input int n, input int cycles);
        int         ptr, held, g;
        logic [3:0] pend, mask;
        logic       rdy, rst;
        vec_t       v;
        ptr = 0; held = -1; pend = '0;
        mask = (n == 3) ? 4'b0111 : 4'b1111;
        for (int c = 0; c < cycles; c++) begin
            rst  = (c == 0) ? 1'b0 : ($urandom_range(0, 39) != 0);
            rdy  = ($urandom_range(0, 9) < 7);
            pend = pend | (4'($urandom) & 4'($urandom) & mask);
            g    = rst ? mgrant(n, ptr, held, pend) : -1;
            v    = mk(rst, pend, rdy, (g >= 0) ? 4'(1 << g) : 4'b0,
                      (g >= 0) ? 2'(g) : 2'b0, (g >= 0 && rdy) ? 4'(1 << g) : 4'b0);
            cyc(n, v, (n == 3) ? "rand3" : "rand4");
            if (!rst) begin
                ptr = 0; held = -1;
            end else if (g >= 0 && rdy) begin
                ptr = (g + 1) % n; held = -1; pend[g] = 1'b0;
            end else if (g >= 0) begin
                held = g;
            end
        end
    endtask

    // Structural invariants on both instances every cycle.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(if4.grant_onehot) || $countones(if4.ack) > 1 ||
            (if4.valid !== |if4.grant_onehot) ||
            ((if4.grant_onehot != 0) ? !if4.grant_onehot[if4.grant_idx] : (if4.grant_idx != 0))) begin
            errors++;
            $display("FAIL inv4: grant %b idx %0d valid %b ack %b", if4.grant_onehot, if4.grant_idx, if4.valid, if4.ack);
        end
        checks++;
        if (!$onehot0(if3.grant_onehot) || $countones(if3.ack) > 1 || if3.grant_idx > 2'd2 ||
            (if3.valid !== |if3.grant_onehot) ||
            ((if3.grant_onehot != 0) ? !if3.grant_onehot[if3.grant_idx] : (if3.grant_idx != 0))) begin
            errors++;
            $display("FAIL inv3: grant %b idx %0d valid %b ack %b", if3.grant_onehot, if3.grant_idx, if3.valid, if3.ack);
        end
    end

    vec_t tbl4[$];
    vec_t tbl3[$];

    initial begin
        checks = 0; errors = 0;
        rst4_n = 1'b0; rst3_n = 1'b0;
        if4.req = '0; if4.ready = 1'b0;
        if3.req = '0; if3.ready = 1'b0;

        tbl4.push_back(mk(0, 4'b1111, 1, 4'b0000, 0, 4'b0000));
        for (int r = 0; r < 2; r++) begin
            tbl4.push_back(mk(1, 4'b1111, 1, 4'b0001, 0, 4'b0001));
            tbl4.push_back(mk(1, 4'b1111, 1, 4'b0010, 1, 4'b0010));
            tbl4.push_back(mk(1, 4'b1111, 1, 4'b0100, 2, 4'b0100));
            tbl4.push_back(mk(1, 4'b1111, 1, 4'b1000, 3, 4'b1000));
        end
        tbl4.push_back(mk(1, 4'b0010, 1, 4'b0010, 1, 4'b0010));
        tbl4.push_back(mk(1, 4'b0011, 1, 4'b0001, 0, 4'b0001));
        tbl4.push_back(mk(1, 4'b0011, 1, 4'b0010, 1, 4'b0010));
        for (int r = 0; r < 5; r++) tbl4.push_back(mk(1, 4'b0000, 1, 4'b0000, 0, 4'b0000));
        tbl4.push_back(mk(1, 4'b1011, 1, 4'b1000, 3, 4'b1000));
        tbl4.push_back(mk(1, 4'b0100, 0, 4'b0100, 2, 4'b0000));
        tbl4.push_back(mk(1, 4'b0101, 0, 4'b0100, 2, 4'b0000));
        tbl4.push_back(mk(1, 4'b0101, 0, 4'b0100, 2, 4'b0000));
        tbl4.push_back(mk(1, 4'b0101, 1, 4'b0100, 2, 4'b0100));
        tbl4.push_back(mk(1, 4'b0001, 1, 4'b0001, 0, 4'b0001));
        tbl4.push_back(mk(1, 4'b1000, 0, 4'b1000, 3, 4'b0000));
        tbl4.push_back(mk(0, 4'b1000, 1, 4'b0000, 0, 4'b0000));
        tbl4.push_back(mk(1, 4'b1111, 1, 4'b0001, 0, 4'b0001));

        tbl3.push_back(mk(0, 4'b0111, 1, 4'b0000, 0, 4'b0000));
        tbl3.push_back(mk(1, 4'b0111, 1, 4'b0001, 0, 4'b0001));
        tbl3.push_back(mk(1, 4'b0111, 1, 4'b0010, 1, 4'b0010));
        tbl3.push_back(mk(1, 4'b0111, 1, 4'b0100, 2, 4'b0100));
        tbl3.push_back(mk(1, 4'b0111, 1, 4'b0001, 0, 4'b0001));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl4.size(); i++) cyc(4, tbl4[i], $sformatf("vec4[%0d]", i));
        rand_run(4, 400);
        rst4_n = 1'b0;
        for (int i = 0; i < tbl3.size(); i++) cyc(3, tbl3[i], $sformatf("vec3[%0d]", i));
        rand_run(3, 300);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
